// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder, one coded symbol per information bit plus K-1 tail symbols per frame.
// Latency: one cycle from input accept to out_valid; single output register, full throughput.
// Backpressure: out_valid & !out_ready freezes out_sym and all state; in_ready drops until the sink takes it.
module conv_encoder #(
    parameter int             N_BITS = 140,
    parameter int             K      = 7,
    parameter logic [K-1:0]   G0     = 7'o171,
    parameter logic [K-1:0]   G1     = 7'o133
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_sym,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(N_BITS + K);

    typedef enum logic [1:0] {IDLE, ENC, TAIL, FLUSH} state_t;

    state_t         state;
    logic [K-2:0]   sr;
    logic [CW-1:0]  cnt;

    logic           adv;
    logic           push_bit;
    logic [K-1:0]   v;
    logic [1:0]     sym_nxt;

    // The output register can take a new symbol when empty or being drained this cycle.
    assign adv      = !out_valid || out_ready;
    assign in_ready = (state == ENC) && adv;

    // Tail bits are self-injected zeros; v[K-1] is the newest bit, v[0] the oldest.
    assign push_bit = (state == TAIL) ? 1'b0 : in_bit;
    assign v        = {push_bit, sr};
    assign sym_nxt  = {^(v & G0), ^(v & G1)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            out_sym   <= 2'b00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ENC;
                        sr    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ENC: begin
                    if (in_valid && in_ready) begin
                        out_sym   <= sym_nxt;
                        out_valid <= 1'b1;
                        sr        <= v[K-1:1];
                        if (cnt == CW'(N_BITS - 1)) begin
                            cnt   <= '0;
                            state <= TAIL;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                TAIL: begin
                    if (adv) begin
                        out_sym   <= sym_nxt;
                        out_valid <= 1'b1;
                        sr        <= v[K-1:1];
                        if (cnt == CW'(K - 2)) begin
                            cnt   <= '0;
                            state <= FLUSH;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Last tail symbol is sitting in the output register.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: impulse response, zero/random/stalled frames, mid-frame reset, ignored start/in_valid.
module tb_conv_encoder;

    localparam int NB   = 140;
    localparam int NSYM = NB + 6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       start, in_bit, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [1:0] out_sym;
    logic       i_start, i_in_bit, i_in_valid, i_in_ready, i_out_valid, i_out_ready, i_busy, i_done;
    logic [1:0] i_out_sym;

    conv_encoder u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .out_sym(out_sym), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    conv_encoder #(.N_BITS(1)) u_imp (
        .clk(clk), .reset_n(reset_n), .start(i_start), .in_bit(i_in_bit), .in_valid(i_in_valid),
        .in_ready(i_in_ready), .out_sym(i_out_sym), .out_valid(i_out_valid), .out_ready(i_out_ready),
        .busy(i_busy), .done(i_done)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: generators 171/133 octal written out in binary, newest bit at v[6].
    logic [5:0] m_sr;
    logic [1:0] exp_q[$];

    function automatic logic [1:0] ref_sym(input logic [6:0] v);
        return {^(v & 7'b1111001), ^(v & 7'b1011011)};
    endfunction

    task automatic model_push(input logic b);
        logic [6:0] v;
        v = {b, m_sr};
        exp_q.push_back(ref_sym(v));
        m_sr = v[6:1];
    endtask

    task automatic run_frame(input string nm, input bit rnd_bits, input bit rnd_stall,
                             input bit poke, input int abort_at, input int exp_cycles);
        int fed, nsym, cyc, ndone;
        bit stalled, fin, aborted, hs_in, hs_out;
        logic [1:0] held, s;
        fed = 0; nsym = 0; cyc = 0; ndone = 0;
        stalled = 0; fin = 0; aborted = 0; held = 2'b00;
        m_sr = '0;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            cyc++;
            if (stalled) begin
                check({nm, " hold vld"}, 32'(out_valid), 32'd1);
                check({nm, " hold sym"}, 32'(out_sym), 32'(held));
            end
            check({nm, " busy"}, 32'(busy), 32'(!done));
            if (done) begin
                ndone++;
                fin = 1;
                check({nm, " symbol count"}, nsym, NSYM);
                check({nm, " leftover"}, exp_q.size(), 0);
                if (exp_cycles > 0) check({nm, " frame cycles"}, cyc - 1, exp_cycles);
            end else begin
                out_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                if (fed < NB) begin
                    in_valid = rnd_stall ? ($urandom_range(0, 4) != 0) : 1'b1;
                    in_bit   = rnd_bits ? 1'($urandom_range(0, 1)) : 1'b0;
                end else begin
                    in_valid = poke;
                    in_bit   = poke;
                end
                #1;
                hs_in  = in_valid && in_ready;
                hs_out = out_valid && out_ready;
                if (fed >= NB) check({nm, " in_ready after last bit"}, 32'(in_ready), 32'd0);
                stalled = out_valid && !out_ready;
                held    = out_sym;
                if (hs_out) begin
                    nsym++;
                    s = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                    check($sformatf("%s sym%0d", nm, nsym), 32'(out_sym), 32'(s));
                end
                if (hs_in && fed < NB) begin
                    model_push(in_bit);
                    fed++;
                    if (fed == NB) repeat (6) model_push(1'b0);
                end
                if (abort_at > 0 && hs_out && nsym == abort_at) begin
                    @(posedge clk);
                    #2;
                    reset_n = 1'b0;
                    #1;
                    check({nm, " rst out_valid"}, 32'(out_valid), 32'd0);
                    check({nm, " rst out_sym"}, 32'(out_sym), 32'd0);
                    check({nm, " rst busy"}, 32'(busy), 32'd0);
                    check({nm, " rst done"}, 32'(done), 32'd0);
                    check({nm, " rst in_ready"}, 32'(in_ready), 32'd0);
                    in_valid = 1'b0; start = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                    reset_n = 1'b1;
                    repeat (4) begin
                        @(negedge clk);
                        check({nm, " post-rst out_valid"}, 32'(out_valid), 32'd0);
                        check({nm, " post-rst done"}, 32'(done), 32'd0);
                        check({nm, " post-rst busy"}, 32'(busy), 32'd0);
                    end
                    fin = 1;
                    aborted = 1;
                end
                if (!fin) @(negedge clk);
            end
        end
        start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        if (!aborted) check({nm, " done pulses"}, ndone, 1);
    endtask

    initial begin
        logic [13:0] imp_pat;
        logic [1:0]  e;
        int          k;
        bit          seen;

        start = 0; in_bit = 0; in_valid = 0; out_ready = 0;
        i_start = 0; i_in_bit = 0; i_in_valid = 0; i_out_ready = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_sym", 32'(out_sym), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("release out_valid", 32'(out_valid), 32'd0);
        check("release busy", 32'(busy), 32'd0);

        // Impulse response of the K=7 171/133 code.
        imp_pat = 14'b11_10_11_11_00_01_11;
        i_start = 1'b1; i_out_ready = 1'b1; i_in_bit = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_in_valid = 1'b1;
        check("imp in_ready", 32'(i_in_ready), 32'd1);
        check("imp out_valid first", 32'(i_out_valid), 32'd0);
        k = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (i_done) begin
                seen = 1;
                check("imp done after 7", k, 7);
                check("imp busy at done", 32'(i_busy), 32'd0);
            end else begin
                if (i_out_valid) begin
                    e = (k < 7) ? imp_pat[13 - 2 * k -: 2] : 2'bxx;
                    check($sformatf("imp sym%0d", k), 32'(i_out_sym), 32'(e));
                    k++;
                end
                @(negedge clk);
            end
        end
        check("imp done seen", 32'(seen), 32'd1);
        i_in_valid = 1'b0;
        @(negedge clk);
        check("imp done one cycle", 32'(i_done), 32'd0);

        run_frame("zero", 1'b0, 1'b0, 1'b0, 0, NB + 6 + 1);
        run_frame("rand", 1'b1, 1'b0, 1'b0, 0, NB + 6 + 1);
        run_frame("stall", 1'b1, 1'b1, 1'b0, 0, 0);
        run_frame("abort", 1'b1, 1'b1, 1'b0, 70, 0);
        run_frame("fresh", 1'b1, 1'b0, 1'b0, 0, NB + 6 + 1);
        run_frame("poke", 1'b1, 1'b1, 1'b1, 0, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
